dac_spi_frame_receiver: RTL and testbench

//  Receive end of the 4-lane AD5541A-style serial DAC bus: SCK, per-lane CS_N and SDI, shared LDAC_N.

---
 rtl/dac_spi_frame_receiver.sv | 184 ++++++++++++++++++
 tb/tb_dac_spi_frame_receiver.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_frame_receiver.sv
// Loopback monitor for a multi-lane AD5541A-style DAC bus: synchronises SCK/CS_N/SDI/LDAC_N
// into clk_50, deserialises each lane and commits the loaded words on the LDAC_N falling edge.
module dac_spi_frame_receiver #(
    parameter int unsigned N_LANES     = 4,
    parameter int unsigned WORD_BITS   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk_50,
    input  logic                         reset_n,
    input  logic                         sck,
    input  logic [N_LANES-1:0]           cs_n,
    input  logic [N_LANES-1:0]           sdi,
    input  logic                         ldac_n,
    input  logic                         err_clear,
    output logic [N_LANES*WORD_BITS-1:0] lane_data,
    output logic                         data_valid,
    output logic [N_LANES-1:0]           lane_mask,
    output logic [N_LANES-1:0]           frame_error,
    output logic [15:0]                  frame_count
);

    // Bus vector layout: [0]=sck, [1]=ldac_n, then cs_n lanes, then sdi lanes.
    localparam int unsigned NS = 2 * N_LANES + 2;
    localparam int unsigned NE = N_LANES + 2;
    localparam logic [4:0]  CNT_MAX  = 5'd31;
    localparam logic [4:0]  CNT_FULL = 5'(WORD_BITS);
    localparam logic [N_LANES*WORD_BITS-1:0] MIDSCALE =
        {N_LANES{1'b1, {(WORD_BITS-1){1'b0}}}};

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } lane_state_e;

    logic [NS-1:0]                sync_q [SYNC_STAGES];
    logic [NS-1:0]                sync_d [SYNC_STAGES];
    logic [NE-1:0]                dly_q, dly_d;
    logic [NS-1:0]                bus_s;

    logic                         sck_rise;
    logic                         ldac_fall;
    logic [N_LANES-1:0]           cs_s, cs_rise, cs_fall, sdi_s;

    lane_state_e                  state_q [N_LANES];
    lane_state_e                  state_d [N_LANES];
    logic [WORD_BITS-1:0]         shift_q [N_LANES];
    logic [WORD_BITS-1:0]         shift_d [N_LANES];
    logic [WORD_BITS-1:0]         hold_q  [N_LANES];
    logic [WORD_BITS-1:0]         hold_d  [N_LANES];
    logic [4:0]                   cnt_q   [N_LANES];
    logic [4:0]                   cnt_d   [N_LANES];
    logic [N_LANES-1:0]           loaded_q, loaded_d;
    logic [N_LANES-1:0]           armed_q, armed_d;
    logic [N_LANES-1:0]           frame_error_q, frame_error_d;
    logic [N_LANES-1:0]           err_set, shifting;

    logic [N_LANES*WORD_BITS-1:0] lane_data_q, lane_data_d;
    logic                         data_valid_q, data_valid_d;
    logic [N_LANES-1:0]           lane_mask_q, lane_mask_d;
    logic [15:0]                  frame_count_q, frame_count_d;

    always_comb begin
        sync_d[0] = {sdi, cs_n, ldac_n, sck};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        bus_s = sync_q[SYNC_STAGES-1];
        dly_d = bus_s[NE-1:0];
    end

    assign sck_rise  = bus_s[0] & ~dly_q[0];
    assign ldac_fall = ~bus_s[1] & dly_q[1];
    assign cs_s      = bus_s[2 +: N_LANES];
    assign cs_rise   = cs_s & ~dly_q[2 +: N_LANES];
    assign cs_fall   = ~cs_s & dly_q[2 +: N_LANES];
    assign sdi_s     = bus_s[2+N_LANES +: N_LANES];

    always_comb begin
        err_set       = '0;
        shifting      = '0;
        loaded_d      = loaded_q;
        armed_d       = armed_q | cs_s;
        lane_data_d   = lane_data_q;
        data_valid_d  = ldac_fall;
        lane_mask_d   = lane_mask_q;
        frame_count_d = frame_count_q;

        for (int unsigned n = 0; n < N_LANES; n++) begin
            state_d[n] = state_q[n];
            shift_d[n] = shift_q[n];
            hold_d[n]  = hold_q[n];
            cnt_d[n]   = cnt_q[n];

            if (state_q[n] == ST_IDLE) begin
                if (cs_fall[n] && armed_q[n]) begin
                    state_d[n] = ST_SHIFT;
                    cnt_d[n]   = '0;
                    shift_d[n] = '0;
                end
            end else begin
                // Shift before close so an sck rise coinciding with cs_n rise still counts.
                if (sck_rise) begin
                    shift_d[n] = {shift_q[n][WORD_BITS-2:0], sdi_s[n]};
                    if (cnt_q[n] != CNT_MAX) begin
                        cnt_d[n] = cnt_q[n] + 5'd1;
                    end
                end
                if (cs_rise[n]) begin
                    state_d[n] = ST_IDLE;
                    if (cnt_d[n] == CNT_FULL) begin
                        hold_d[n]   = shift_d[n];
                        loaded_d[n] = 1'b1;
                    end else begin
                        err_set[n] = 1'b1;
                    end
                end
            end
            shifting[n] = (state_d[n] == ST_SHIFT);
        end

        // Commit sees this cycle's closes, so a word closing with the ldac fall joins it.
        if (ldac_fall) begin
            lane_mask_d = loaded_d & ~shifting;
            for (int unsigned n = 0; n < N_LANES; n++) begin
                if (lane_mask_d[n]) begin
                    lane_data_d[n*WORD_BITS +: WORD_BITS] = hold_d[n];
                end
            end
            loaded_d = '0;
            if (|lane_mask_d) begin
                frame_count_d = frame_count_q + 16'd1;
            end
        end

        frame_error_d = (frame_error_q & ~{N_LANES{err_clear}}) | err_set;
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            dly_q <= '0;
            for (int unsigned n = 0; n < N_LANES; n++) begin
                state_q[n] <= ST_IDLE;
                shift_q[n] <= '0;
                hold_q[n]  <= '0;
                cnt_q[n]   <= '0;
            end
            loaded_q      <= '0;
            armed_q       <= '0;
            frame_error_q <= '0;
            lane_data_q   <= MIDSCALE;
            data_valid_q  <= 1'b0;
            lane_mask_q   <= '0;
            frame_count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            dly_q <= dly_d;
            for (int unsigned n = 0; n < N_LANES; n++) begin
                state_q[n] <= state_d[n];
                shift_q[n] <= shift_d[n];
                hold_q[n]  <= hold_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
            loaded_q      <= loaded_d;
            armed_q       <= armed_d;
            frame_error_q <= frame_error_d;
            lane_data_q   <= lane_data_d;
            data_valid_q  <= data_valid_d;
            lane_mask_q   <= lane_mask_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign lane_data   = lane_data_q;
    assign data_valid  = data_valid_q;
    assign lane_mask   = lane_mask_q;
    assign frame_error = frame_error_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_dac_spi_frame_receiver.sv
// Bench for dac_spi_frame_receiver: drives the serial DAC bus and compares commits against
// a transaction-level model of loaded words, errors and the commit counter.
module tb_dac_spi_frame_receiver;

    localparam int NL = 4;
    localparam int WB = 16;

    logic              clk_50 = 1'b0;
    logic              reset_n = 1'b0;
    logic              sck = 1'b0;
    logic              ldac_n = 1'b1;
    logic              err_clear = 1'b0;
    logic [NL-1:0]     cs_n = '1;
    logic [NL-1:0]     sdi = '0;
    logic [NL*WB-1:0]  lane_data;
    logic              data_valid;
    logic [NL-1:0]     lane_mask;
    logic [NL-1:0]     frame_error;
    logic [15:0]       frame_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WB-1:0] m_data  [NL];
    logic [WB-1:0] m_hold  [NL];
    logic [WB-1:0] tx_word [NL];
    int            tx_pos  [NL];
    logic [NL-1:0] m_loaded, m_err, m_open;
    logic [15:0]   m_count;

    always #10 clk_50 = ~clk_50;

    dac_spi_frame_receiver #(
        .N_LANES    (NL),
        .WORD_BITS  (WB),
        .SYNC_STAGES(2)
    ) dut (
        .clk_50     (clk_50),
        .reset_n    (reset_n),
        .sck        (sck),
        .cs_n       (cs_n),
        .sdi        (sdi),
        .ldac_n     (ldac_n),
        .err_clear  (err_clear),
        .lane_data  (lane_data),
        .data_valid (data_valid),
        .lane_mask  (lane_mask),
        .frame_error(frame_error),
        .frame_count(frame_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    function automatic logic [63:0] model_data();
        logic [63:0] r;
        r = '0;
        for (int l = 0; l < NL; l++) r[l*WB +: WB] = m_data[l];
        return r;
    endfunction

    task automatic do_reset(input logic [NL-1:0] cs_at_reset);
        @(negedge clk_50);
        reset_n = 1'b0;
        cs_n = cs_at_reset;
        sck = 1'b0;
        ldac_n = 1'b1;
        sdi = '0;
        wait_clks(3);
        reset_n = 1'b1;
        for (int l = 0; l < NL; l++) begin
            m_data[l] = 16'h8000;
            m_hold[l] = '0;
            tx_pos[l] = 0;
        end
        m_loaded = '0;
        m_err = '0;
        m_open = '0;
        m_count = '0;
        wait_clks(2);
        check("rst_data", lane_data, {4{16'h8000}});
        check("rst_dv", data_valid, 0);
        check("rst_mask", lane_mask, 0);
        check("rst_err", frame_error, 0);
        check("rst_count", frame_count, 0);
    endtask

    task automatic open_lanes(input logic [NL-1:0] m, input logic [63:0] words);
        for (int l = 0; l < NL; l++) begin
            if (m[l]) begin
                cs_n[l] = 1'b0;
                tx_word[l] = words[l*WB +: WB];
                tx_pos[l] = 0;
            end
        end
        m_open = m_open | m;
        wait_clks(3);
    endtask

    task automatic clock_bits(input int nb);
        repeat (nb) begin
            for (int l = 0; l < NL; l++) begin
                if (!cs_n[l]) begin
                    if (tx_pos[l] < WB) sdi[l] = tx_word[l][WB-1-tx_pos[l]];
                    else sdi[l] = 1'($urandom);
                    tx_pos[l]++;
                end
            end
            wait_clks(3);
            sck = 1'b1;
            wait_clks(3);
            sck = 1'b0;
        end
    endtask

    task automatic close_lanes(input logic [NL-1:0] m);
        cs_n = cs_n | m;
        for (int l = 0; l < NL; l++) begin
            if (m[l] && m_open[l]) begin
                if (tx_pos[l] == WB) begin
                    m_hold[l] = tx_word[l];
                    m_loaded[l] = 1'b1;
                end else begin
                    m_err[l] = 1'b1;
                end
            end
        end
        m_open = m_open & ~m;
        wait_clks(3);
        check("close_err", frame_error, m_err);
    endtask

    task automatic send_frame(input logic [NL-1:0] m, input logic [63:0] words);
        open_lanes(m, words);
        clock_bits(WB);
        close_lanes(m);
    endtask

    task automatic commit();
        logic [NL-1:0] exp_mask;
        int lat;
        exp_mask = m_loaded & ~m_open;
        for (int l = 0; l < NL; l++) if (exp_mask[l]) m_data[l] = m_hold[l];
        m_loaded = '0;
        if (exp_mask != 0) m_count = m_count + 16'd1;
        ldac_n = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_50);
            if (data_valid) begin
                lat = k;
                break;
            end
        end
        check("dv_latency", lat, 3);
        check("commit_mask", lane_mask, exp_mask);
        check("commit_data", lane_data, model_data());
        check("commit_count", frame_count, m_count);
        @(negedge clk_50);
        check("dv_single", data_valid, 0);
        ldac_n = 1'b1;
        wait_clks(3);
    endtask

    task automatic pulse_err_clear();
        err_clear = 1'b1;
        @(negedge clk_50);
        err_clear = 1'b0;
        m_err = '0;
        @(negedge clk_50);
        check("err_clear", frame_error, m_err);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NL-1:0] rm;
        logic [63:0]   rw;
        int            nb [NL];
        int            maxb;

        do_reset('1);

        // All four lanes, then commit.
        send_frame(4'hF, {16'hFFFF, 16'h0000, 16'hABCD, 16'h1234});
        commit();

        // Lane 2 alone; other lanes keep previous codes.
        send_frame(4'b0100, {16'h0000, 16'h7FFF, 16'h0000, 16'h0000});
        commit();

        // Short and long frames raise errors and commit nothing.
        open_lanes(4'b0011, {32'h0, 16'h1111, 16'h2222});
        clock_bits(15);
        close_lanes(4'b0001);
        clock_bits(2);
        close_lanes(4'b0010);
        check("err_short_long", frame_error, 4'b0011);
        commit();
        pulse_err_clear();

        // Commit while lane 3 is mid-frame.
        send_frame(4'b0001, {48'h0, 16'hC3A5});
        open_lanes(4'b1000, {16'h5A3C, 48'h0});
        clock_bits(8);
        commit();
        clock_bits(8);
        close_lanes(4'b1000);
        commit();

        // Frame open at reset release is ignored.
        do_reset(4'b1101);
        tx_word[1] = 16'($urandom);
        tx_pos[1] = 0;
        clock_bits(16);
        close_lanes(4'b0010);
        check("ignored_no_err", frame_error, 0);
        send_frame(4'b0010, {32'h0, 16'h5555, 16'h0});
        commit();

        // Counter wrap from a preloaded value.
        @(negedge clk_50);
        force dut.frame_count_q = 16'hFFFE;
        @(negedge clk_50);
        release dut.frame_count_q;
        m_count = 16'hFFFE;
        wait_clks(2);
        check("preload_hold", frame_count, m_count);
        send_frame(4'b0001, {48'h0, 16'h0F0F});
        commit();
        send_frame(4'b1001, {16'hF00D, 32'h0, 16'hBEEF});
        commit();
        check("wrap_zero", frame_count, 16'h0000);

        // Randomised frames with occasional wrong bit counts.
        for (int it = 0; it < 24; it++) begin
            rm = 4'($urandom_range(1, 15));
            rw = {$urandom, $urandom};
            maxb = 0;
            for (int l = 0; l < NL; l++) begin
                nb[l] = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 18) : WB;
                if (rm[l] && nb[l] > maxb) maxb = nb[l];
            end
            open_lanes(rm, rw);
            for (int b = 1; b <= maxb; b++) begin
                clock_bits(1);
                for (int l = 0; l < NL; l++) begin
                    if (rm[l] && nb[l] == b) close_lanes(4'(1 << l));
                end
            end
            if ($urandom_range(0, 2) == 0) pulse_err_clear();
            if ($urandom_range(0, 4) != 0) commit();
        end
        commit();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
